// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared definitions for the register-bank write-port arbiter.
// Requester indices and the round-robin pointer helper.
package regfile_wr_arbiter_pkg;

  localparam int NUM_REQ = 3;

  localparam logic [1:0] REQ_ALU = 2'd0;
  localparam logic [1:0] REQ_MEM = 2'd1;
  localparam logic [1:0] REQ_MDU = 2'd2;

  typedef logic [NUM_REQ-1:0] req_mask_t;

  // Pointer moves to the requester after the port-A winner.
  function automatic logic [1:0] ptr_after(req_mask_t pick);
    logic [1:0] p;
    p = REQ_ALU;
    unique case (1'b1)
      pick[REQ_ALU]: p = REQ_MEM;
      pick[REQ_MEM]: p = REQ_MDU;
      pick[REQ_MDU]: p = REQ_ALU;
      default:       p = REQ_ALU;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/regfile_wr_arbiter_rr_pick3.sv
// Round-robin one-hot pick among three requesters.
// Search starts at ptr and wraps; excluded requesters are skipped.
module rr_pick3
  import regfile_wr_arbiter_pkg::*;
(
  input  req_mask_t  elig,
  input  logic [1:0] ptr,
  input  req_mask_t  excl,
  output req_mask_t  pick,
  output logic       found
);

  req_mask_t  cand;
  logic [1:0] idx;

  assign cand = elig & ~excl;

  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = 2'((32'(ptr) + k) % NUM_REQ);
      if (!found && cand[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Two-port register-bank write arbiter for ALU, load and mul/div.
// Round-robin grants, registered bank writes, pending-dest check.
module regfile_wr_arbiter
  import regfile_wr_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      alu_wr_valid_in,
  input  logic                      mem_wr_valid_in,
  input  logic                      mdu_wr_valid_in,
  input  logic [REG_ADDR_WIDTH-1:0] alu_wr_addr_in,
  input  logic [REG_ADDR_WIDTH-1:0] mem_wr_addr_in,
  input  logic [REG_ADDR_WIDTH-1:0] mdu_wr_addr_in,
  input  logic [DATA_WIDTH-1:0]     alu_wr_data_in,
  input  logic [DATA_WIDTH-1:0]     mem_wr_data_in,
  input  logic [DATA_WIDTH-1:0]     mdu_wr_data_in,
  output logic                      alu_wr_ready_out,
  output logic                      mem_wr_ready_out,
  output logic                      mdu_wr_ready_out,
  output logic [REG_ADDR_WIDTH-1:0] reg_a_wr_addr_out,
  output logic [REG_ADDR_WIDTH-1:0] reg_b_wr_addr_out,
  output logic [DATA_WIDTH-1:0]     reg_a_wr_data_out,
  output logic [DATA_WIDTH-1:0]     reg_b_wr_data_out,
  output logic                      reg_a_wr_en_out,
  output logic                      reg_b_wr_en_out,
  input  logic [REG_ADDR_WIDTH-1:0] chk_addr1_in,
  input  logic [REG_ADDR_WIDTH-1:0] chk_addr2_in,
  output logic                      chk_addr1_pending_out,
  output logic                      chk_addr2_pending_out
);

  logic [REG_ADDR_WIDTH-1:0] addr [NUM_REQ];
  logic [DATA_WIDTH-1:0]     data [NUM_REQ];

  req_mask_t valid, elig, zero, nz, same;
  req_mask_t pick_a, pick_b, ready;
  logic      found_a, found_b;
  logic      hit1, hit2;
  logic [1:0] ptr;

  logic [REG_ADDR_WIDTH-1:0] a_addr, b_addr;
  logic [DATA_WIDTH-1:0]     a_data, b_data;

  assign valid = {mdu_wr_valid_in, mem_wr_valid_in, alu_wr_valid_in};

  assign addr[REQ_ALU] = alu_wr_addr_in;
  assign addr[REQ_MEM] = mem_wr_addr_in;
  assign addr[REQ_MDU] = mdu_wr_addr_in;
  assign data[REQ_ALU] = alu_wr_data_in;
  assign data[REQ_MEM] = mem_wr_data_in;
  assign data[REQ_MDU] = mdu_wr_data_in;

  assign elig = valid & {NUM_REQ{en & rst_n}};
  assign nz   = elig & ~zero;

  always_comb begin
    zero = '0;
    for (int i = 0; i < NUM_REQ; i++)
      zero[i] = (addr[i] == '0);
  end

  rr_pick3 u_pick_a (
    .elig  (nz),
    .ptr   (ptr),
    .excl  ('0),
    .pick  (pick_a),
    .found (found_a)
  );

  always_comb begin
    a_addr = '0;
    a_data = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (pick_a[i]) begin
        a_addr = addr[i];
        a_data = data[i];
      end
  end

  // Same-destination losers retry so A and B never share a register.
  always_comb begin
    same = '0;
    for (int i = 0; i < NUM_REQ; i++)
      same[i] = (addr[i] == a_addr);
  end

  rr_pick3 u_pick_b (
    .elig  (nz),
    .ptr   (ptr),
    .excl  (pick_a | same),
    .pick  (pick_b),
    .found (found_b)
  );

  always_comb begin
    b_addr = '0;
    b_data = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (pick_b[i]) begin
        b_addr = addr[i];
        b_data = data[i];
      end
  end

  // r0 writes are acknowledged and dropped.
  assign ready = (elig & zero) | pick_a | pick_b;

  assign alu_wr_ready_out = ready[REQ_ALU];
  assign mem_wr_ready_out = ready[REQ_MEM];
  assign mdu_wr_ready_out = ready[REQ_MDU];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr               <= REQ_ALU;
      reg_a_wr_en_out   <= 1'b0;
      reg_b_wr_en_out   <= 1'b0;
      reg_a_wr_addr_out <= '0;
      reg_b_wr_addr_out <= '0;
      reg_a_wr_data_out <= '0;
      reg_b_wr_data_out <= '0;
    end else begin
      reg_a_wr_en_out <= found_a;
      reg_b_wr_en_out <= found_b;
      if (found_a) begin
        reg_a_wr_addr_out <= a_addr;
        reg_a_wr_data_out <= a_data;
        ptr               <= ptr_after(pick_a);
      end
      if (found_b) begin
        reg_b_wr_addr_out <= b_addr;
        reg_b_wr_data_out <= b_data;
      end
    end
  end

  always_comb begin
    hit1 = (reg_a_wr_en_out && reg_a_wr_addr_out == chk_addr1_in)
        || (reg_b_wr_en_out && reg_b_wr_addr_out == chk_addr1_in);
    hit2 = (reg_a_wr_en_out && reg_a_wr_addr_out == chk_addr2_in)
        || (reg_b_wr_en_out && reg_b_wr_addr_out == chk_addr2_in);
    for (int i = 0; i < NUM_REQ; i++) begin
      hit1 = hit1 | (valid[i] && addr[i] == chk_addr1_in);
      hit2 = hit2 | (valid[i] && addr[i] == chk_addr2_in);
    end
  end

  assign chk_addr1_pending_out = rst_n && (chk_addr1_in != '0) && hit1;
  assign chk_addr2_pending_out = rst_n && (chk_addr2_in != '0) && hit2;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Self-checking bench for regfile_wr_arbiter.
// Directed scenarios plus random traffic against a queue-level model.
module tb_regfile_wr_arbiter;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        v [3];
  logic [4:0]  a [3];
  logic [31:0] d [3];
  logic [4:0]  chk1, chk2;

  logic        r0, r1, r2;
  logic [2:0]  rdy;
  logic [4:0]  oa_addr, ob_addr;
  logic [31:0] oa_data, ob_data;
  logic        oa_en, ob_en, p1, p2;

  int total = 0;
  int bad   = 0;

  int          m_ptr;
  logic        m_en_a, m_en_b;
  logic [4:0]  m_addr_a, m_addr_b;
  logic [31:0] m_data_a, m_data_b;
  logic [2:0]  exp_rdy;
  int          exp_ga, exp_gb;

  assign rdy = {r2, r1, r0};

  regfile_wr_arbiter dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .en                    (en),
    .alu_wr_valid_in       (v[0]),
    .mem_wr_valid_in       (v[1]),
    .mdu_wr_valid_in       (v[2]),
    .alu_wr_addr_in        (a[0]),
    .mem_wr_addr_in        (a[1]),
    .mdu_wr_addr_in        (a[2]),
    .alu_wr_data_in        (d[0]),
    .mem_wr_data_in        (d[1]),
    .mdu_wr_data_in        (d[2]),
    .alu_wr_ready_out      (r0),
    .mem_wr_ready_out      (r1),
    .mdu_wr_ready_out      (r2),
    .reg_a_wr_addr_out     (oa_addr),
    .reg_b_wr_addr_out     (ob_addr),
    .reg_a_wr_data_out     (oa_data),
    .reg_b_wr_data_out     (ob_data),
    .reg_a_wr_en_out       (oa_en),
    .reg_b_wr_en_out       (ob_en),
    .chk_addr1_in          (chk1),
    .chk_addr2_in          (chk2),
    .chk_addr1_pending_out (p1),
    .chk_addr2_pending_out (p2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Walk the priority ring from ptr: r0 requests are free,
  // first real write takes A, next one with another dest takes B.
  task automatic predict();
    int order [$];
    exp_rdy = '0;
    exp_ga  = -1;
    exp_gb  = -1;
    if (!(rst_n && en)) return;
    for (int k = 0; k < 3; k++) order.push_back((m_ptr + k) % 3);
    foreach (order[j]) begin
      int r = order[j];
      if (!v[r]) continue;
      if (a[r] == 0) begin
        exp_rdy[r] = 1'b1;
      end else if (exp_ga < 0) begin
        exp_ga = r;
        exp_rdy[r] = 1'b1;
      end else if (exp_gb < 0 && a[r] != a[exp_ga]) begin
        exp_gb = r;
        exp_rdy[r] = 1'b1;
      end
    end
  endtask

  function automatic logic exp_pend(logic [4:0] c);
    if (!rst_n || c == 0) return 1'b0;
    if (m_en_a && m_addr_a == c) return 1'b1;
    if (m_en_b && m_addr_b == c) return 1'b1;
    for (int i = 0; i < 3; i++)
      if (v[i] && a[i] == c) return 1'b1;
    return 1'b0;
  endfunction

  task automatic tick();
    predict();
    @(posedge clk);
    if (!rst_n) begin
      m_ptr = 0;
      m_en_a = 0; m_en_b = 0;
      m_addr_a = 0; m_addr_b = 0;
      m_data_a = 0; m_data_b = 0;
    end else begin
      m_en_a = (exp_ga >= 0);
      m_en_b = (exp_gb >= 0);
      if (exp_ga >= 0) begin
        m_addr_a = a[exp_ga];
        m_data_a = d[exp_ga];
        m_ptr = (exp_ga + 1) % 3;
      end
      if (exp_gb >= 0) begin
        m_addr_b = a[exp_gb];
        m_data_b = d[exp_gb];
      end
    end
    #1;
  endtask

  task automatic set_req(int i, logic vv, int ad, logic [31:0] dd);
    v[i] = vv;
    a[i] = 5'(ad);
    d[i] = dd;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en = 1'b1;
    chk1 = 0; chk2 = 0;
    for (int i = 0; i < 3; i++) set_req(i, 1'b0, 0, 0);
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en = 1'b1;
    set_req(0, 1'b1, 3, 32'h1111_0000);
    set_req(1, 1'b1, 4, 32'h2222_0000);
    set_req(2, 1'b1, 5, 32'h3333_0000);
    chk1 = 3; chk2 = 4;
    #1;
    total++;
    if (rdy !== 3'b000) begin
      bad++; $display("FAIL rst_ready got=%b exp=000", rdy);
    end
    total++;
    if ({p1, p2} !== 2'b00) begin
      bad++; $display("FAIL rst_pending got=%b exp=00", {p1, p2});
    end
    tick();
    total++;
    if ({oa_en, ob_en, oa_addr, ob_addr, oa_data, ob_data} !== '0) begin
      bad++;
      $display("FAIL rst_outs got en=%b%b a=%0d b=%0d exp all 0",
               oa_en, ob_en, oa_addr, ob_addr);
    end
    rst_n = 1'b1;
    chk1 = 0; chk2 = 0;
    #1;
    total++;
    if (rdy !== 3'b011) begin
      bad++; $display("FAIL rst_release_ready got=%b exp=011", rdy);
    end
    tick();
    total++;
    if ({oa_en, oa_addr, ob_en, ob_addr} !== {1'b1, 5'd3, 1'b1, 5'd4}) begin
      bad++;
      $display("FAIL rst_release_out got A=%b/%0d B=%b/%0d exp A=1/3 B=1/4",
               oa_en, oa_addr, ob_en, ob_addr);
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] rr_rdy [3] = '{3'b011, 3'b110, 3'b101};
    int rr_a [3] = '{3, 4, 5};
    int rr_b [3] = '{4, 5, 3};
    do_reset();
    for (int i = 0; i < 3; i++)
      set_req(i, 1'b1, i + 3, 32'(((i + 1) << 8)));
    for (int c = 0; c < 3; c++) begin
      #1;
      total++;
      if (rdy !== rr_rdy[c]) begin
        bad++; $display("FAIL rr_ready c%0d got=%b exp=%b", c, rdy, rr_rdy[c]);
      end
      tick();
      total++;
      if ({oa_en, ob_en} !== 2'b11 || oa_addr !== 5'(rr_a[c])
          || ob_addr !== 5'(rr_b[c])) begin
        bad++;
        $display("FAIL rr_addr c%0d got A=%0d B=%0d exp A=%0d B=%0d",
                 c, oa_addr, ob_addr, rr_a[c], rr_b[c]);
      end
      total++;
      if (oa_data !== m_data_a || ob_data !== m_data_b) begin
        bad++;
        $display("FAIL rr_data c%0d got %h/%h exp %h/%h",
                 c, oa_data, ob_data, m_data_a, m_data_b);
      end
      for (int i = 0; i < 3; i++)
        if (exp_rdy[i]) d[i] = d[i] + 1;
    end
  endtask

  task automatic test_same_addr();
    do_reset();
    set_req(0, 1'b1, 7, 32'hA1A1_A1A1);
    set_req(1, 1'b1, 7, 32'hB2B2_B2B2);
    #1;
    total++;
    if (rdy !== 3'b001) begin
      bad++; $display("FAIL same_ready1 got=%b exp=001", rdy);
    end
    tick();
    total++;
    if ({oa_en, oa_addr, oa_data, ob_en} !== {1'b1, 5'd7, 32'hA1A1_A1A1, 1'b0}) begin
      bad++;
      $display("FAIL same_out1 got A=%b/%0d/%h Ben=%b exp A=1/7/a1a1a1a1 Ben=0",
               oa_en, oa_addr, oa_data, ob_en);
    end
    v[0] = 1'b0;
    #1;
    total++;
    if (rdy !== 3'b010) begin
      bad++; $display("FAIL same_ready2 got=%b exp=010", rdy);
    end
    tick();
    total++;
    if ({oa_en, oa_addr, oa_data, ob_en} !== {1'b1, 5'd7, 32'hB2B2_B2B2, 1'b0}) begin
      bad++;
      $display("FAIL same_out2 got A=%b/%0d/%h Ben=%b exp A=1/7/b2b2b2b2 Ben=0",
               oa_en, oa_addr, oa_data, ob_en);
    end
  endtask

  task automatic test_zero_reg();
    do_reset();
    set_req(0, 1'b1, 3, 32'h0000_0A0A);
    set_req(1, 1'b1, 4, 32'h0000_0B0B);
    set_req(2, 1'b1, 0, 32'h0000_0C0C);
    #1;
    total++;
    if (rdy !== 3'b111) begin
      bad++; $display("FAIL zero_ready got=%b exp=111", rdy);
    end
    tick();
    total++;
    if ({oa_en, oa_addr, ob_en, ob_addr} !== {1'b1, 5'd3, 1'b1, 5'd4}) begin
      bad++;
      $display("FAIL zero_out got A=%b/%0d B=%b/%0d exp A=1/3 B=1/4",
               oa_en, oa_addr, ob_en, ob_addr);
    end
  endtask

  task automatic test_stall();
    do_reset();
    for (int i = 0; i < 3; i++)
      set_req(i, 1'b1, i + 3, 32'(i + 100));
    tick();
    for (int i = 0; i < 3; i++)
      if (exp_rdy[i]) d[i] = d[i] + 10;
    en = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++;
      if (rdy !== 3'b000) begin
        bad++; $display("FAIL stall_ready c%0d got=%b exp=000", c, rdy);
      end
      tick();
      total++;
      if ({oa_en, ob_en} !== 2'b00) begin
        bad++; $display("FAIL stall_en c%0d got=%b exp=00", c, {oa_en, ob_en});
      end
    end
    en = 1'b1;
    #1;
    total++;
    if (rdy !== 3'b110) begin
      bad++; $display("FAIL stall_resume_ready got=%b exp=110", rdy);
    end
    tick();
    total++;
    if ({oa_addr, ob_addr, oa_data} !== {5'd4, 5'd5, 32'd111}) begin
      bad++;
      $display("FAIL stall_resume_out got A=%0d B=%0d Ad=%0d exp 4 5 111",
               oa_addr, ob_addr, oa_data);
    end
  endtask

  task automatic test_pending();
    do_reset();
    set_req(1, 1'b1, 9, 32'h0909_0909);
    chk1 = 9; chk2 = 0;
    #1;
    total++;
    if ({p1, p2} !== 2'b10) begin
      bad++; $display("FAIL pend_req got=%b exp=10", {p1, p2});
    end
    tick();
    v[1] = 1'b0;
    #1;
    total++;
    if ({p1, p2} !== 2'b10) begin
      bad++; $display("FAIL pend_reg got=%b exp=10", {p1, p2});
    end
    tick();
    total++;
    if ({p1, p2} !== 2'b00) begin
      bad++; $display("FAIL pend_commit got=%b exp=00", {p1, p2});
    end
  endtask

  task automatic test_random();
    do_reset();
    exp_rdy = '1;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 3; i++)
        if (!v[i] || exp_rdy[i]) begin
          v[i] = ($urandom_range(0, 3) != 0);
          a[i] = 5'($urandom_range(0, 7));
          d[i] = $urandom;
        end
      en   = ($urandom_range(0, 7) != 0);
      chk1 = 5'($urandom_range(0, 7));
      chk2 = 5'($urandom_range(0, 7));
      #1;
      predict();
      total++;
      if (rdy !== exp_rdy) begin
        bad++; $display("FAIL rnd_ready c%0d got=%b exp=%b", c, rdy, exp_rdy);
      end
      total++;
      if ({p1, p2} !== {exp_pend(chk1), exp_pend(chk2)}) begin
        bad++;
        $display("FAIL rnd_pending c%0d got=%b exp=%b", c, {p1, p2},
                 {exp_pend(chk1), exp_pend(chk2)});
      end
      tick();
      total++;
      if ({oa_en, ob_en} !== {m_en_a, m_en_b}) begin
        bad++;
        $display("FAIL rnd_en c%0d got=%b exp=%b", c, {oa_en, ob_en},
                 {m_en_a, m_en_b});
      end
      total++;
      if ({oa_addr, oa_data, ob_addr, ob_data}
          !== {m_addr_a, m_data_a, m_addr_b, m_data_b}) begin
        bad++;
        $display("FAIL rnd_out c%0d got A=%0d/%h B=%0d/%h exp A=%0d/%h B=%0d/%h",
                 c, oa_addr, oa_data, ob_addr, ob_data,
                 m_addr_a, m_data_a, m_addr_b, m_data_b);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    chk1  = 0;
    chk2  = 0;
    for (int i = 0; i < 3; i++) set_req(i, 1'b0, 0, 0);
    m_ptr = 0;
    m_en_a = 0; m_en_b = 0;
    m_addr_a = 0; m_addr_b = 0;
    m_data_a = 0; m_data_b = 0;
    @(negedge clk);
    test_reset();
    test_round_robin();
    test_same_addr();
    test_zero_reg();
    test_stall();
    test_pending();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
